// File: rtl/pdecod_pkg.sv
// Shared types and helpers for the priority-grant decoder return path.
package pdecod_pkg;

    localparam int N_OUT_DEF = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/pdecod_grant_dec_onehot.sv
// Combinational index-to-one-hot conversion; out-of-range indices yield all zeros.
module dec_onehot
    import pdecod_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N_OUT-1:0] onehot,
    output logic             in_rng
);

    always_comb begin
        in_rng = in_range(32'(idx), N_OUT);
        onehot = '0;
        for (int i = 0; i < N_OUT; i++) begin
            onehot[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/pdecod_grant.sv
// Registered priority-grant decoder: accepts an encoded winner, holds its one-hot
// grant until done or timeout, then inserts one dead cycle before the next grant.
module pdecod_grant
    import pdecod_pkg::*;
#(
    parameter int N_OUT   = N_OUT_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [N_OUT-1:0] done,
    output logic [N_OUT-1:0] q,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout_err,
    output logic             bad_code
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [N_OUT-1:0] dec_q;
    logic             dec_ok;
    logic             accept;
    logic             release_hit;
    logic             expire;

    dec_onehot #(
        .N_OUT (N_OUT),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx    (code_in),
        .onehot (dec_q),
        .in_rng (dec_ok)
    );

    assign code_ready = (state == IDLE) & ~rst;
    assign busy       = (state != IDLE);
    assign accept     = code_valid & code_ready;

    // q holds exactly the granted line, so masking done with q selects done[grant_idx].
    assign release_hit = |(done & q);
    assign expire      = (TIMEOUT != 0) && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q           <= '0;
            grant_idx   <= '0;
            timeout_err <= 1'b0;
            bad_code    <= 1'b0;
            count       <= '0;
        end else begin
            timeout_err <= 1'b0;
            bad_code    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_ok) begin
                            q         <= dec_q;
                            grant_idx <= code_in;
                            count     <= CNT_W'(TIMEOUT);
                            state     <= GRANT;
                        end else begin
                            bad_code <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    // done takes precedence over a timeout landing on the same edge
                    if (release_hit) begin
                        q     <= '0;
                        state <= RELEASE;
                    end else if (expire) begin
                        q           <= '0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else if (TIMEOUT != 0) begin
                        count <= count - CNT_W'(1);
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdecod_grant.sv
// Scoreboard bench for pdecod_grant: random transactions predicted at the
// transaction level (grant length, timeout, bad code) and checked by a monitor.
module tb_pdecod_grant;

    localparam int N  = 6;
    localparam int T  = 4;
    localparam int IW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] code_in;
    logic          code_valid;
    logic          code_ready;
    logic [N-1:0]  done;
    logic [N-1:0]  q;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout_err;
    logic          bad_code;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit is_bad;
        int idx;
        int len;
        bit tmo;
    } exp_t;

    exp_t sbq[$];
    int   model_last_idx = 0;

    always #5 clk = ~clk;

    pdecod_grant #(
        .N_OUT   (N),
        .IDX_W   (IW),
        .TIMEOUT (T),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .done        (done),
        .q           (q),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .bad_code    (bad_code)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic int q_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One transaction: optional idle gap, offer code, then drive done for the
    // granted line on grant cycle dly (dly > T means the requester never releases).
    task automatic txn(input int code, input int dly, input int gap);
        exp_t e;
        int   n;
        repeat (gap) begin
            done = N'($urandom);
            @(negedge clk);
        end
        code_in    = IW'(code);
        code_valid = 1'b1;
        n = 0;
        while (!code_ready && n < 40) begin
            done = N'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            fail_now("ready_wait_expired");
            code_valid = 1'b0;
            return;
        end
        e.is_bad = (code >= N);
        e.idx    = e.is_bad ? model_last_idx : code;
        e.len    = (dly <= T) ? dly : T;
        e.tmo    = (dly > T);
        sbq.push_back(e);
        if (!e.is_bad) model_last_idx = code;
        @(negedge clk);
        code_valid = 1'b0;
        code_in    = IW'($urandom);
        if (e.is_bad) return;
        for (int k = 1; k <= e.len; k++) begin
            done = N'($urandom) & ~(N'(1) << code);
            if (k == dly) done = done | (N'(1) << code);
            @(negedge clk);
        end
        done = '0;
    endtask

    // Reset asserted during grant cycle k of code 2, with code 2 still offered.
    task automatic rst_test(input int k);
        int n;
        code_in    = IW'(2);
        code_valid = 1'b1;
        n = 0;
        while (!code_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("rst_pre_q", q, 32'h4);
        repeat (k - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_q", q, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tmo", timeout_err, 0);
        chk("rst_mid_gidx", grant_idx, 0);
        chk("rst_mid_ready", code_ready, 1);
        @(negedge clk);
        chk("rst_reaccept_q", q, 32'h4);
        chk("rst_reaccept_gidx", grant_idx, 2);
        code_valid = 1'b0;
        done = N'(6'b000100);
        @(negedge clk);
        done = '0;
        chk("rst_rel_q", q, 0);
        chk("rst_rel_busy", busy, 1);
        chk("rst_rel_ready", code_ready, 0);
        chk("rst_rel_tmo", timeout_err, 0);
        @(negedge clk);
        chk("rst_idle_ready", code_ready, 1);
    endtask

    logic [N-1:0] prev_q = '0;
    int           cur_len = 0;
    bit           rel_seen = 1'b0;
    exp_t         me;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bad_code) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_bad_code");
                end else begin
                    me = sbq.pop_front();
                    chk("bad_kind", 1, me.is_bad);
                    chk("bad_q_zero", q, 0);
                    chk("bad_keep_gidx", grant_idx, me.idx);
                    chk("bad_not_busy", busy, 0);
                end
            end
            if (q != '0) begin
                chk("onehot", $countones(q), 1);
                chk("tmo_in_grant", timeout_err, 0);
                if (prev_q == '0) begin
                    cur_len = 1;
                    chk("grant_busy", busy, 1);
                    chk("grant_ready_low", code_ready, 0);
                end else begin
                    chk("q_hold", q, prev_q);
                    cur_len++;
                end
            end else if (prev_q != '0) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    me = sbq.pop_front();
                    chk("grant_kind", 0, me.is_bad);
                    chk("grant_line", q_index(prev_q), me.idx);
                    chk("grant_idx", grant_idx, me.idx);
                    chk("grant_len", cur_len, me.len);
                    chk("timeout_err", timeout_err, me.tmo);
                    chk("release_busy", busy, 1);
                    chk("release_ready", code_ready, 0);
                end
                rel_seen = 1'b1;
            end else begin
                if (rel_seen) begin
                    chk("idle_busy", busy, 0);
                    chk("idle_ready", code_ready, 1);
                    rel_seen = 1'b0;
                end
                chk("tmo_idle", timeout_err, 0);
            end
            prev_q = q;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        code_in    = '0;
        code_valid = 1'b0;
        done       = '0;
        repeat (3) @(negedge clk);
        chk("reset_q", q, 0);
        chk("reset_gidx", grant_idx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tmo", timeout_err, 0);
        chk("reset_bad", bad_code, 0);
        chk("reset_ready", code_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", code_ready, 1);
        @(negedge clk);

        rst_test(2);
        rst_test(4);
        @(negedge clk);
        mon_en = 1'b1;

        txn(3, 2, 0);
        txn(5, 9, 1);
        txn(5, 4, 0);
        txn(6, 1, 0);
        txn(7, 1, 0);
        txn(5, 1, 0);
        txn(0, 3, 2);
        txn(4, 5, 0);
        repeat (150) begin
            txn($urandom_range(0, 7), $urandom_range(1, 6), $urandom_range(0, 3));
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
